issue_reorder_buffer: RTL and testbench
=======================================

Name: issue_reorder_buffer

Overview:
- Parametrised issue-stage reorder queue between the decode/issue-read interface and the issue port of the scoreboard.
- Holds up to DEPTH decoded scoreboard entries in age order.
- Normally issues the oldest entry.
- While the oldest entry is a LOAD/STORE and the LSU is not ready, issues the oldest younger independent ALU-class entry instead. This hides LSU back-pressure without violating register dependences.

Parameters:
- DEPTH, 4, number of queue slots (2..8); count width is $clog2(DEPTH+1).
- MAX_BYPASS, 3, maximum consecutive bypass issues before the head is forced (starvation bound, 1..15).

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  synchronous active-low reset, sampled on rising clk_i edge
- flush_i  in  1  drop all queued entries
- issue_entry_i  in  ariane_pkg::scoreboard_entry_t  incoming decoded instruction
- issue_entry_valid_i  in  1  issue_entry_i valid
- is_ctrl_flow_i  in  1  incoming instruction is control flow
- issue_instr_ack_o  out  1  upstream accept; transfer occurs when valid_i & ack_o
- issue_entry_o  out  ariane_pkg::scoreboard_entry_t  selected entry
- issue_entry_valid_o  out  1  selected entry valid
- is_ctrl_flow_o  out  1  control-flow flag of selected entry
- issue_instr_ack_i  in  1  downstream consumed selected entry this cycle
- lsu_ready_i  in  1  LSU can accept a memory op

Behaviour:
- Reset (rst_ni=0 at edge):
  - All slots invalid, count=0, bypass counter=0.
  - Outputs while in reset: valid_o=0, ack_o=0, entry_o='0, is_ctrl_flow_o=0.
- Storage:
  - Slot 0 is the oldest (shift-compaction queue).
  - Removing slot k shifts slots k+1..count-1 down by one in the same edge.
- Enqueue:
  - ack_o = (count < DEPTH) & ~flush_i. It is not combinationally dependent on issue_instr_ack_i.
  - An accepted entry is written at position count minus one if a removal occurs in the same cycle, else at position count.
  - Latency: the entry is visible at the output the cycle after acceptance.
- Selection (combinational from state plus lsu_ready_i):
  - sel = 0 by default.
  - bypass_allowed = slot0 fu ∈ {LOAD, STORE} & ~lsu_ready_i & bypass counter < MAX_BYPASS.
  - If bypass_allowed, sel = the smallest k ≥ 1 with slot k valid and eligible:
    - fu ∉ {LOAD, STORE, CTRL_FLOW, CSR} and ~is_ctrl_flow;
    - no slot j < k has fu CTRL_FLOW/CSR or is_ctrl_flow (barrier);
    - for every j < k, with only nonzero register indices compared: k.rs1≠j.rd, k.rs2≠j.rd, k.rd≠j.rs1, k.rd≠j.rs2, k.rd≠j.rd.
  - If no k qualifies, sel = 0.
- Outputs:
  - issue_entry_o/is_ctrl_flow_o = slot[sel].
  - valid_o = (count > 0) & ~flush_i.
- Dequeue: when issue_instr_ack_i & valid_o, remove slot[sel]; count decrements unless an enqueue occurs in the same cycle.
- Bypass counter:
  - Increments on each dequeue with sel ≠ 0, saturating at MAX_BYPASS.
  - Clears on a dequeue with sel = 0, on flush, and on reset.
- Full with simultaneous dequeue: no enqueue that cycle; count becomes DEPTH-1.
- Empty: valid_o=0; issue_instr_ack_i is ignored.
- Flush:
  - Takes priority over enqueue and dequeue.
  - Next state: count=0, counter=0.
  - valid_o and ack_o forced 0 during the flush cycle.
- Reset mid-operation: discards all contents identically to flush, with no residual state.
- issue_instr_ack_i asserted with valid_o=0 is a protocol violation; a bench assertion flags it.

Optional Feature:
- Macro: ISSUE_REORDER_PASSTHROUGH_EN.
- Defined: when count==0 and ~flush_i:
  - issue_entry_o/valid_o/is_ctrl_flow_o mirror the inputs combinationally;
  - ack_o=1;
  - the entry is enqueued only if issue_instr_ack_i=0 (zero-latency issue).
- Undefined: fixed 1-cycle latency, as specified above.

Decomposition:
- ariane_pkg additions:
  - function is_mem_fu(fu_t);
  - function is_barrier(scoreboard_entry_t, logic ctrl);
  - localparam ISSUE_REORDER_DEPTH = 4.
- Sub-module issue_reorder_hazard: purely combinational. Given a candidate entry and one older entry, it outputs a conflict bit. The top instantiates DEPTH*(DEPTH-1)/2 copies via generate. Queue, selection and counter logic stay in the top.

Test Plan:
- Reset then idle: rst_ni=0 for 2 cycles, then 1 with no input → valid_o=0 and ack_o=1 throughout post-reset; count=0.
- In-order fill: push ADD x1, SUB x2, OR x3 with lsu_ready_i=1 and ack_i=1 every cycle → issued in order x1, x2, x3, each appearing 1 cycle after acceptance.
- Bypass (lsu_ready_i=0):
  - Queue LOAD x5←(x6), ADD x7=x8+x9 → ADD issued first.
  - When lsu_ready_i returns to 1, LOAD is issued.
- Hazard block: queue LOAD x5, ADD x7=x5+x1, lsu_ready_i=0 → ADD is not selected; LOAD is held at the output until lsu_ready_i=1.
- Starvation and barrier (DEPTH=4, MAX_BYPASS=3):
  - Queue STORE, then 4 independent ADDs supplied continuously, lsu_ready_i=0 → 3 ADDs bypass, then the STORE is selected.
  - A BRANCH placed before an ADD prevents that ADD from bypassing.
- Full and flush:
  - Fill 4 entries with ack_i=0 → ack_o=0.
  - Assert flush_i with valid_i=1 → valid_o=0 and ack_o=0 in that cycle; the next cycle count=0 and the input was not captured.

Source files
------------

// File: rtl/issue_reorder_buffer_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : issue_reorder_buffer_pkg                                         |
// | Purpose  : Types and helpers shared by the issue reorder queue. Contains     |
// |            the subset of the ariane_pkg scoreboard entry that the queue      |
// |            reads, the functional-unit classes, and the classification        |
// |            helpers used by both the queue and its hazard checker.            |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
package issue_reorder_buffer_pkg;

   localparam int ISSUE_REORDER_DEPTH = 4;

   typedef enum logic [3:0] {
      NONE      = 4'd0,
      LOAD      = 4'd1,
      STORE     = 4'd2,
      ALU       = 4'd3,
      CTRL_FLOW = 4'd4,
      MULT      = 4'd5,
      CSR       = 4'd6,
      FPU       = 4'd7
   } fu_t;

   typedef struct packed {
      logic [31:0] pc;
      fu_t         fu;
      logic [7:0]  op;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
   } scoreboard_entry_t;

   // Register indices of one entry, the only fields the hazard check needs.
   typedef struct packed {
      logic [4:0] rs1;
      logic [4:0] rs2;
      logic [4:0] rd;
   } reg_use_t;

   function automatic logic is_mem_fu(input fu_t fu);
      return (fu == LOAD) || (fu == STORE);
   endfunction

   // Nothing younger may be issued past a control-flow or CSR instruction.
   function automatic logic is_barrier(input scoreboard_entry_t entry, input logic ctrl);
      return (entry.fu == CTRL_FLOW) || (entry.fu == CSR) || ctrl;
   endfunction

   function automatic reg_use_t regs_of(input scoreboard_entry_t entry);
      reg_use_t r;
      r.rs1 = entry.rs1;
      r.rs2 = entry.rs2;
      r.rd  = entry.rd;
      return r;
   endfunction

   // x0 never creates a dependence.
   function automatic logic reg_clash(input logic [4:0] a, input logic [4:0] b);
      return (a != 5'd0) && (a == b);
   endfunction

endpackage
`default_nettype wire

// File: rtl/issue_reorder_buffer_if.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : issue_reorder_buffer_if                                          |
// | Purpose  : Decode-side and issue-side handshake of the issue reorder queue.  |
// |   flush_i             drop all queued entries                               |
// |   issue_entry_i       incoming decoded instruction (+ valid, ctrl flag)     |
// |   issue_instr_ack_o   upstream accept                                       |
// |   issue_entry_o       selected entry (+ valid, ctrl flag)                   |
// |   issue_instr_ack_i   downstream consumed the selected entry                |
// |   lsu_ready_i         LSU can accept a memory op                            |
// |   slave modport: the queue; master modport: its environment.                |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
interface issue_reorder_buffer_if;
   import issue_reorder_buffer_pkg::*;

   logic              flush_i;
   scoreboard_entry_t issue_entry_i;
   logic              issue_entry_valid_i;
   logic              is_ctrl_flow_i;
   logic              issue_instr_ack_o;
   scoreboard_entry_t issue_entry_o;
   logic              issue_entry_valid_o;
   logic              is_ctrl_flow_o;
   logic              issue_instr_ack_i;
   logic              lsu_ready_i;

   modport slave (
      input  flush_i, issue_entry_i, issue_entry_valid_i, is_ctrl_flow_i,
      input  issue_instr_ack_i, lsu_ready_i,
      output issue_instr_ack_o, issue_entry_o, issue_entry_valid_o, is_ctrl_flow_o
   );

   modport master (
      output flush_i, issue_entry_i, issue_entry_valid_i, is_ctrl_flow_i,
      output issue_instr_ack_i, lsu_ready_i,
      input  issue_instr_ack_o, issue_entry_o, issue_entry_valid_o, is_ctrl_flow_o
   );

endinterface
`default_nettype wire

// File: rtl/issue_reorder_hazard.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : issue_reorder_hazard                                             |
// | Purpose  : Decides whether a candidate entry may be issued ahead of one      |
// |            specific older entry. Purely combinational.                       |
// |   i_cand           register indices of the candidate                        |
// |   i_older          register indices of the older entry                      |
// |   i_older_barrier  older entry is control flow / CSR                        |
// |   o_conflict       candidate must not pass the older entry                  |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
module issue_reorder_hazard
   import issue_reorder_buffer_pkg::*;
(
   input  reg_use_t i_cand,
   input  reg_use_t i_older,
   input  logic     i_older_barrier,
   output logic     o_conflict
);

   // RAW on either source, WAR on either older source, and WAW.
   always_comb begin
      o_conflict = i_older_barrier
                 | reg_clash(i_cand.rs1, i_older.rd)
                 | reg_clash(i_cand.rs2, i_older.rd)
                 | reg_clash(i_cand.rd,  i_older.rs1)
                 | reg_clash(i_cand.rd,  i_older.rs2)
                 | reg_clash(i_cand.rd,  i_older.rd);
   end

endmodule
`default_nettype wire

// File: rtl/issue_reorder_buffer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : issue_reorder_buffer                                             |
// | Purpose  : Age-ordered issue queue in front of the scoreboard issue port.    |
// |            Issues the oldest entry, except while a LOAD/STORE at the head    |
// |            is blocked by the LSU: then the oldest younger, independent       |
// |            ALU-class entry goes first (at most MAX_BYPASS times in a row).   |
// |   clk_i   clock                                                             |
// |   rst_ni  synchronous active-low reset                                      |
// |   bus     issue_reorder_buffer_if.slave (decode and issue handshakes)       |
// | Option   : `define ISSUE_REORDER_PASSTHROUGH_EN gives zero-latency issue     |
// |            when the queue is empty.                                          |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
module issue_reorder_buffer
   import issue_reorder_buffer_pkg::*;
#(
   parameter int DEPTH      = ISSUE_REORDER_DEPTH,
   parameter int MAX_BYPASS = 3
) (
   input  logic                   clk_i,
   input  logic                   rst_ni,
   issue_reorder_buffer_if.slave  bus
);

   localparam int c_CNT_W = $clog2(DEPTH + 1);
   localparam int c_IDX_W = $clog2(DEPTH);
   localparam int c_BYP_W = $clog2(MAX_BYPASS + 1);
   localparam logic [c_CNT_W-1:0] c_DEPTH   = c_CNT_W'(DEPTH);
   localparam logic [c_BYP_W-1:0] c_MAX_BYP = c_BYP_W'(MAX_BYPASS);

   // Slot 0 is always the oldest; slots at or above r_count are don't-care.
   scoreboard_entry_t    r_slot [DEPTH];
   logic [DEPTH-1:0]     r_ctrl;
   logic [c_CNT_W-1:0]   r_count;
   logic [c_BYP_W-1:0]   r_byp_cnt;

   scoreboard_entry_t    w_slot_nxt [DEPTH];
   logic [DEPTH-1:0]     w_ctrl_nxt;
   logic [c_CNT_W-1:0]   w_count_nxt;
   logic [c_CNT_W-1:0]   w_wpos;
   logic [c_BYP_W-1:0]   w_byp_nxt;
   logic [DEPTH-1:0]     w_conflict [DEPTH];
   logic [c_IDX_W-1:0]   w_sel;
   logic                 w_found;
   logic                 w_bypass_allowed;
   logic                 w_pass;
   logic                 w_ack_o;
   logic                 w_valid_o;
   logic                 w_issue;
   logic                 w_enq;
   logic                 w_deq;

   // One checker per (candidate k, older j) pair with j < k.
   for (genvar k = 0; k < DEPTH; k++) begin : g_cand
      for (genvar j = 0; j < DEPTH; j++) begin : g_older
         if (j < k) begin : g_pair
            issue_reorder_hazard u_hazard (
               .i_cand          (regs_of(r_slot[k])),
               .i_older         (regs_of(r_slot[j])),
               .i_older_barrier (is_barrier(r_slot[j], r_ctrl[j])),
               .o_conflict      (w_conflict[k][j])
            );
         end else begin : g_none
            assign w_conflict[k][j] = 1'b0;
         end
      end
   end

   // Selection: head unless it is a stalled memory op with bypass budget left.
   always_comb begin
      w_bypass_allowed = (r_count != '0) && is_mem_fu(r_slot[0].fu)
                       && !bus.lsu_ready_i && (r_byp_cnt < c_MAX_BYP);
      w_sel   = '0;
      w_found = 1'b0;
      if (w_bypass_allowed) begin
         for (int k = 1; k < DEPTH; k++) begin
            if (!w_found && (c_CNT_W'(k) < r_count)
                && !is_mem_fu(r_slot[k].fu)
                && !is_barrier(r_slot[k], r_ctrl[k])
                && (w_conflict[k] == '0)) begin
               w_sel   = c_IDX_W'(k);
               w_found = 1'b1;
            end
         end
      end
   end

   // Handshakes and outputs; everything is held at zero while in reset.
   always_comb begin
      w_pass                 = 1'b0;
      w_ack_o                = rst_ni && (r_count < c_DEPTH) && !bus.flush_i;
      w_valid_o              = rst_ni && (r_count != '0) && !bus.flush_i;
      bus.issue_entry_o      = rst_ni ? r_slot[w_sel] : '0;
      bus.is_ctrl_flow_o     = rst_ni && r_ctrl[w_sel];
`ifdef ISSUE_REORDER_PASSTHROUGH_EN
      if (rst_ni && (r_count == '0) && !bus.flush_i) begin
         w_pass             = 1'b1;
         w_valid_o          = bus.issue_entry_valid_i;
         bus.issue_entry_o  = bus.issue_entry_i;
         bus.is_ctrl_flow_o = bus.is_ctrl_flow_i;
      end
`endif
      bus.issue_instr_ack_o   = w_ack_o;
      bus.issue_entry_valid_o = w_valid_o;
      w_issue = bus.issue_instr_ack_i && w_valid_o;
      // A pass-through issue consumes the input directly; nothing is stored.
      w_deq   = w_issue && !w_pass;
      w_enq   = bus.issue_entry_valid_i && w_ack_o && !(w_pass && bus.issue_instr_ack_i);
   end

   // Next state: compact over the removed slot, then append behind the survivors.
   always_comb begin
      w_slot_nxt = r_slot;
      w_ctrl_nxt = r_ctrl;
      w_wpos     = r_count - c_CNT_W'(w_deq);
      for (int i = 0; i < DEPTH - 1; i++) begin
         if (w_deq && (c_IDX_W'(i) >= w_sel)) begin
            w_slot_nxt[i] = r_slot[i+1];
            w_ctrl_nxt[i] = r_ctrl[i+1];
         end
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (w_enq && (c_CNT_W'(i) == w_wpos)) begin
            w_slot_nxt[i] = bus.issue_entry_i;
            w_ctrl_nxt[i] = bus.is_ctrl_flow_i;
         end
      end
      w_count_nxt = r_count + c_CNT_W'(w_enq) - c_CNT_W'(w_deq);
      w_byp_nxt   = r_byp_cnt;
      if (w_issue) begin
         if (w_deq && (w_sel != '0)) begin
            if (r_byp_cnt < c_MAX_BYP) begin
               w_byp_nxt = r_byp_cnt + 1'b1;
            end
         end else begin
            w_byp_nxt = '0;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         for (int i = 0; i < DEPTH; i++) begin
            r_slot[i] <= '0;
         end
         r_ctrl    <= '0;
         r_count   <= '0;
         r_byp_cnt <= '0;
      end else if (bus.flush_i) begin
         r_count   <= '0;
         r_byp_cnt <= '0;
      end else begin
         r_slot    <= w_slot_nxt;
         r_ctrl    <= w_ctrl_nxt;
         r_count   <= w_count_nxt;
         r_byp_cnt <= w_byp_nxt;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_issue_reorder_buffer.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | Module   : tb_issue_reorder_buffer                                          |
// | Purpose  : Self-checking bench for issue_reorder_buffer. A queue-based model |
// |            predicts every cycle's outputs; directed scenarios add literal    |
// |            expectations; a randomized phase follows.                         |
// | Revision : 1.0  initial release                                             |
// +-----------------------------------------------------------------------------+
module tb_issue_reorder_buffer;
   import issue_reorder_buffer_pkg::*;

   localparam int DEPTH      = 4;
   localparam int MAX_BYPASS = 3;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   issue_reorder_buffer_if bus ();

   issue_reorder_buffer #(
      .DEPTH      (DEPTH),
      .MAX_BYPASS (MAX_BYPASS)
   ) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   typedef struct {
      scoreboard_entry_t e;
      logic              c;
   } item_t;

   item_t mq[$];
   int    mbyp  = 0;
   int    total = 0;
   int    bad   = 0;

   localparam scoreboard_entry_t NOP = '0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic scoreboard_entry_t mk(input fu_t f, input int s1, input int s2, input int d);
      scoreboard_entry_t e;
      e     = '0;
      e.pc  = 32'h1000 + 32'(d * 4);
      e.fu  = f;
      e.rs1 = 5'(s1);
      e.rs2 = 5'(s2);
      e.rd  = 5'(d);
      return e;
   endfunction

   function automatic bit clash(input logic [4:0] a, input logic [4:0] b);
      return (a != 0) && (a == b);
   endfunction

   // Which queue position must be issued, from the bypass rules.
   function automatic int model_sel();
      bit ok;
      if (mq.size() == 0) return 0;
      if (!(mq[0].e.fu inside {LOAD, STORE}) || bus.lsu_ready_i || mbyp >= MAX_BYPASS) return 0;
      for (int k = 1; k < mq.size(); k++) begin
         ok = !(mq[k].e.fu inside {LOAD, STORE, CTRL_FLOW, CSR}) && !mq[k].c;
         for (int j = 0; j < k; j++) begin
            if (mq[j].e.fu inside {CTRL_FLOW, CSR} || mq[j].c) ok = 0;
            if (clash(mq[k].e.rs1, mq[j].e.rd) || clash(mq[k].e.rs2, mq[j].e.rd) ||
                clash(mq[k].e.rd, mq[j].e.rs1) || clash(mq[k].e.rd, mq[j].e.rs2) ||
                clash(mq[k].e.rd, mq[j].e.rd)) ok = 0;
         end
         if (ok) return k;
      end
      return 0;
   endfunction

   // Compare process: check outputs, then advance the model to the next edge.
   always @(negedge clk) begin
      int                sel;
      bit                ev, ea, ec, pass, enq, deq;
      scoreboard_entry_t ee;
      #2;
      sel  = 0;
      pass = 0;
      if (!rst_n) begin
         ev = 0; ea = 0; ec = 0; ee = '0;
      end else begin
         sel = model_sel();
         ea  = (mq.size() < DEPTH) && !bus.flush_i;
         ev  = (mq.size() > 0) && !bus.flush_i;
         ee  = (mq.size() > 0) ? mq[sel].e : '0;
         ec  = (mq.size() > 0) ? mq[sel].c : 1'b0;
`ifdef ISSUE_REORDER_PASSTHROUGH_EN
         if (mq.size() == 0 && !bus.flush_i) begin
            pass = 1; ea = 1; ev = bus.issue_entry_valid_i;
            ee = bus.issue_entry_i; ec = bus.is_ctrl_flow_i;
         end
`endif
      end
      chk("valid_o", 64'(bus.issue_entry_valid_o), 64'(ev));
      chk("ack_o", 64'(bus.issue_instr_ack_o), 64'(ea));
      if (ev || !rst_n) begin
         chk("entry_o", 64'(bus.issue_entry_o), 64'(ee));
         chk("ctrl_o", 64'(bus.is_ctrl_flow_o), 64'(ec));
      end
      if (rst_n && bus.issue_instr_ack_i && !bus.issue_entry_valid_o) begin
         bad++;
         $display("FAIL protocol: ack_i=1 while valid_o=0 at %0t", $time);
      end
      if (!rst_n || bus.flush_i) begin
         mq.delete();
         mbyp = 0;
      end else begin
         deq = bus.issue_instr_ack_i && ev;
         enq = bus.issue_entry_valid_i && ea && !(pass && bus.issue_instr_ack_i);
         if (deq && !pass) begin
            mq.delete(sel);
            mbyp = (sel != 0) ? ((mbyp + 1 > MAX_BYPASS) ? MAX_BYPASS : mbyp + 1) : 0;
         end else if (deq) begin
            mbyp = 0;
         end
         if (enq) mq.push_back('{e: bus.issue_entry_i, c: bus.is_ctrl_flow_i});
      end
   end

   // One cycle of stimulus; the downstream only acks what is offered.
   task automatic step(input bit r, input bit fl, input bit v, input scoreboard_entry_t e,
                       input bit c, input bit lsu, input bit ack);
      @(negedge clk);
      rst_n                   = r;
      bus.flush_i             = fl;
      bus.issue_entry_valid_i = v;
      bus.issue_entry_i       = e;
      bus.is_ctrl_flow_i      = c;
      bus.lsu_ready_i         = lsu;
      #1;
      bus.issue_instr_ack_i   = ack && bus.issue_entry_valid_o;
   endtask

   task automatic idle(input bit lsu, input bit ack);
      step(1, 0, 0, NOP, 0, lsu, ack);
   endtask

   fu_t fus[8] = '{ALU, ALU, ALU, MULT, LOAD, STORE, CTRL_FLOW, CSR};

   initial begin
      bus.flush_i = 0; bus.issue_entry_valid_i = 0; bus.issue_entry_i = '0;
      bus.is_ctrl_flow_i = 0; bus.lsu_ready_i = 1; bus.issue_instr_ack_i = 0;

      // Reset then idle
      step(0, 0, 0, NOP, 0, 1, 0);
      chk("rst_valid", 64'(bus.issue_entry_valid_o), 64'(0));
      chk("rst_ack", 64'(bus.issue_instr_ack_o), 64'(0));
      step(0, 0, 0, NOP, 0, 1, 0);
      idle(1, 0);
      chk("idle_valid", 64'(bus.issue_entry_valid_o), 64'(0));
      chk("idle_ack", 64'(bus.issue_instr_ack_o), 64'(1));

      // In-order fill
      step(1, 0, 1, mk(ALU, 0, 0, 1), 0, 1, 1);
      chk("fill_lat", 64'(bus.issue_entry_valid_o), 64'(0));
      step(1, 0, 1, mk(ALU, 0, 0, 2), 0, 1, 1);
      chk("fill_x1", 64'(bus.issue_entry_o.rd), 64'(1));
      step(1, 0, 1, mk(ALU, 0, 0, 3), 0, 1, 1);
      chk("fill_x2", 64'(bus.issue_entry_o.rd), 64'(2));
      idle(1, 1);
      chk("fill_x3", 64'(bus.issue_entry_o.rd), 64'(3));
      idle(1, 1);

      // Bypass of a stalled LOAD
      step(1, 0, 1, mk(LOAD, 6, 0, 5), 0, 0, 0);
      step(1, 0, 1, mk(ALU, 8, 9, 7), 0, 0, 0);
      chk("byp_head", 64'(bus.issue_entry_o.rd), 64'(5));
      idle(0, 1);
      chk("byp_add", 64'(bus.issue_entry_o.rd), 64'(7));
      idle(1, 1);
      chk("byp_load", 64'(bus.issue_entry_o.fu), 64'(LOAD));
      idle(1, 1);

      // RAW hazard blocks the bypass
      step(1, 0, 1, mk(LOAD, 6, 0, 5), 0, 0, 0);
      step(1, 0, 1, mk(ALU, 5, 1, 7), 0, 0, 0);
      idle(0, 0);
      chk("haz_hold", 64'(bus.issue_entry_o.rd), 64'(5));
      idle(1, 1);
      chk("haz_load", 64'(bus.issue_entry_o.rd), 64'(5));
      idle(1, 1);
      chk("haz_add", 64'(bus.issue_entry_o.rd), 64'(7));
      idle(1, 1);

      // Starvation bound
      step(1, 0, 1, mk(STORE, 10, 11, 0), 0, 0, 0);
      step(1, 0, 1, mk(ALU, 20, 21, 12), 0, 0, 0);
      step(1, 0, 1, mk(ALU, 20, 21, 13), 0, 0, 0);
      step(1, 0, 1, mk(ALU, 20, 21, 14), 0, 0, 0);
      step(1, 0, 1, mk(ALU, 20, 21, 15), 0, 0, 1);
      chk("starv_full", 64'(bus.issue_instr_ack_o), 64'(0));
      chk("starv_b1", 64'(bus.issue_entry_o.rd), 64'(12));
      step(1, 0, 1, mk(ALU, 20, 21, 15), 0, 0, 1);
      chk("starv_b2", 64'(bus.issue_entry_o.rd), 64'(13));
      step(1, 0, 1, mk(ALU, 20, 21, 16), 0, 0, 1);
      chk("starv_b3", 64'(bus.issue_entry_o.rd), 64'(14));
      step(1, 0, 1, mk(ALU, 20, 21, 17), 0, 0, 1);
      chk("starv_store", 64'(bus.issue_entry_o.fu), 64'(STORE));
      repeat (4) idle(1, 1);

      // Branch acts as a barrier
      step(1, 0, 1, mk(LOAD, 6, 0, 5), 0, 0, 0);
      step(1, 0, 1, mk(CTRL_FLOW, 1, 2, 0), 1, 0, 0);
      step(1, 0, 1, mk(ALU, 8, 9, 7), 0, 0, 0);
      idle(0, 0);
      chk("barrier_hold", 64'(bus.issue_entry_o.fu), 64'(LOAD));
      repeat (4) idle(1, 1);

      // Full, then flush with a valid input
      for (int i = 0; i < 4; i++) step(1, 0, 1, mk(ALU, 0, 0, 20 + i), 0, 1, 0);
      step(1, 0, 1, mk(ALU, 0, 0, 25), 0, 1, 0);
      chk("full_ack", 64'(bus.issue_instr_ack_o), 64'(0));
      step(1, 1, 1, mk(ALU, 0, 0, 26), 0, 1, 0);
      chk("flush_valid", 64'(bus.issue_entry_valid_o), 64'(0));
      chk("flush_ack", 64'(bus.issue_instr_ack_o), 64'(0));
      idle(1, 0);
      chk("post_flush_valid", 64'(bus.issue_entry_valid_o), 64'(0));
      chk("post_flush_ack", 64'(bus.issue_instr_ack_o), 64'(1));

      // Reset mid-operation
      step(1, 0, 1, mk(ALU, 0, 0, 3), 0, 1, 0);
      step(1, 0, 1, mk(ALU, 0, 0, 4), 0, 1, 0);
      step(0, 0, 1, mk(ALU, 0, 0, 5), 0, 1, 0);
      chk("midrst_entry", 64'(bus.issue_entry_o), 64'(0));
      idle(1, 0);
      chk("midrst_valid", 64'(bus.issue_entry_valid_o), 64'(0));

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         step(($urandom_range(0, 199) != 0), ($urandom_range(0, 39) == 0),
              ($urandom_range(0, 9) < 7),
              mk(fus[$urandom_range(0, 7)], $urandom_range(0, 7), $urandom_range(0, 7),
                 $urandom_range(0, 7)),
              ($urandom_range(0, 9) == 0), $urandom_range(0, 1), ($urandom_range(0, 9) < 6));
      end
      idle(1, 1);
      idle(1, 1);
      @(negedge clk);
      #3;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
